seq_1101_tx: RTL
================

SEQ_1101_TX -- requirements
Module: seq_1101_tx

Interface
REQ-001 SHALL provide parameter PAYLOAD_W, default 8, payload bits per frame (1..32).
REQ-002 SHALL provide parameter PARITY_EN, default 1, appends an even-parity bit after the payload when 1.
REQ-003 SHALL provide parameter GAP, default 2, extra idle cycles after each frame (0..15).
REQ-004 SHALL have port clk  input  1  clock, all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  payload offered.
REQ-007 SHALL have port in_data  input  PAYLOAD_W  payload word.
REQ-008 SHALL have port in_ready  output  1  block can accept a payload.
REQ-009 SHALL have port out  output  1  serial line bit, registered.
REQ-010 SHALL have port out_en  output  1  out carries a frame bit this cycle, registered.
REQ-011 SHALL have port done  output  1  one-cycle pulse on the last frame bit, registered.

Function
REQ-012 SHALL implement states IDLE, SYNC, DATA, PARITY, GAP.
REQ-013 SHALL set in_ready=1 only in IDLE, decoded from the state register.
REQ-014 SHALL accept a payload at a rising edge where in_valid=1 and in_ready=1, latch in_data there, and enter SYNC.
REQ-015 SHALL drive the first sync bit on out, with out_en=1, from that same accepting edge: zero-cycle latency from accept to first bit.
REQ-016 SHALL emit sync word 1,1,0,1 over 4 cycles, then the payload MSB-first over PAYLOAD_W cycles, then one parity bit if PARITY_EN=1.
REQ-017 SHALL compute parity as XOR of all latched payload bits, so total ones in the payload plus parity is even.
REQ-018 SHALL assert done together with the final frame bit: the last payload bit if PARITY_EN=0, otherwise the parity bit.
REQ-019 SHALL drive out=0 and out_en=0 in IDLE and GAP.
REQ-020 SHALL remain in GAP for exactly GAP cycles and then enter IDLE; GAP=0 goes directly to IDLE.
REQ-021 SHALL ignore in_valid and in_data outside IDLE; the latched payload is never modified mid-frame.
REQ-022 SHALL hold frame length at 4+PAYLOAD_W+PARITY_EN out_en cycles; the minimum first-bit-to-first-bit spacing of consecutive frames is frame length + GAP + 1.
REQ-023 SHALL size the bit counter as $clog2(PAYLOAD_W+1) bits, with no wrap inside a frame.

Reset
REQ-024 SHALL, while rst=1, force state=IDLE, out=0, out_en=0, done=0, counters=0, payload register=0; in_ready reads 1 but no accept occurs.
REQ-025 SHALL abort a frame in progress immediately on rst, with no further frame bits; the next frame after release starts with a full sync word.

Structure
REQ-026 SHALL take the state enum, SYNC_WORD=4'b1101 and SYNC_LEN=4 from shared package seq_pkg, also used by the detector side.
REQ-027 SHALL place the loadable MSB-first shift register with parity generation in sub-module seq_piso, instantiated once.

Verification
REQ-028 SHALL check: PAYLOAD_W=8, PARITY_EN=1, accept 8'hA5 -> out=1101 10100101 0, 13 out_en cycles, done on the 13th.
REQ-029 SHALL check: PARITY_EN=0, accept 8'h07 -> out=1101 00000111, 12 out_en cycles, done on the 12th.
REQ-030 SHALL check: in_valid held high, GAP=2, default widths -> second frame's first bit exactly 16 cycles after the first frame's first bit.
REQ-031 SHALL check: 8'h3C accepted, in_data changed to 8'hFF mid-frame -> serialized payload remains 00111100, parity 0.
REQ-032 SHALL check: rst pulsed during payload bit 3 -> out=0, out_en=0 and done=0 asynchronously; after release, accept 8'h01 -> 1101 00000001 1.
REQ-033 SHALL check: accept 8'hFF -> parity bit 0; accept 8'h80 -> parity bit 1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the 1101-sync serial link (transmitter and detector side).
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_GAP    = 3'd4
  } seq_state_t;

  localparam logic [3:0] SYNC_WORD = 4'b1101;
  localparam int         SYNC_LEN  = 4;

  function automatic logic even_parity(input logic [31:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/seq_piso.sv
// Loadable MSB-first shift register; the parity of the loaded word is captured at load time.
module seq_piso import seq_pkg::*; #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] data,
  output logic         msb,
  output logic         parity
);

  logic [W-1:0] sh_r;
  logic         par_r;

  // Shift register and captured parity; contents only change on load or shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_r  <= '0;
      par_r <= 1'b0;
    end else if (load) begin
      sh_r  <= data;
      par_r <= even_parity(32'(data));
    end else if (shift) begin
      sh_r  <= sh_r << 1;
    end
  end

  assign msb    = sh_r[W-1];
  assign parity = par_r;

endmodule

// File: rtl/seq_1101_tx.sv
// Frame transmitter: sync word 1101, payload MSB-first, optional even parity, then idle gap.
module seq_1101_tx import seq_pkg::*; #(
  parameter int PAYLOAD_W = 8,
  parameter int PARITY_EN = 1,
  parameter int GAP       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 in_ready,
  output logic                 out,
  output logic                 out_en,
  output logic                 done
);

  localparam int             CW       = $clog2(PAYLOAD_W + 1);
  localparam logic [CW-1:0]  PW_C     = CW'(PAYLOAD_W);
  localparam logic [CW-1:0]  LAST_IDX = CW'(PAYLOAD_W - 1);
  localparam logic [3:0]     GAP_INIT = 4'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic           PAR_EN   = (PARITY_EN != 0);
  localparam logic           ONE_BIT_LAST = (PAYLOAD_W == 1) && (PARITY_EN == 0);

  seq_state_t    state;
  logic [2:0]    sync_cnt;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    gap_cnt;
  logic          load;
  logic          shift;
  logic          msb;
  logic          parity;

  assign in_ready = (state == ST_IDLE);
  assign load     = in_ready && in_valid;
  assign shift    = ((state == ST_SYNC) && (sync_cnt == 3'(SYNC_LEN))) ||
                    ((state == ST_DATA) && (bit_cnt < PW_C));

  seq_piso #(.W(PAYLOAD_W)) u_piso (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .shift  (shift),
    .data   (in_data),
    .msb    (msb),
    .parity (parity)
  );

  // Frame sequencer; the state names the bit currently on out, so the first sync bit leaves on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sync_cnt <= 3'd0;
      bit_cnt  <= '0;
      gap_cnt  <= 4'd0;
      out      <= 1'b0;
      out_en   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state    <= ST_SYNC;
            out      <= SYNC_WORD[2'(SYNC_LEN - 1)];
            out_en   <= 1'b1;
            sync_cnt <= 3'd1;
          end else begin
            out    <= 1'b0;
            out_en <= 1'b0;
          end
        end
        ST_SYNC: begin
          if (sync_cnt < 3'(SYNC_LEN)) begin
            out      <= SYNC_WORD[2'(3'(SYNC_LEN - 1) - sync_cnt)];
            sync_cnt <= sync_cnt + 3'd1;
          end else begin
            state    <= ST_DATA;
            out      <= msb;
            sync_cnt <= 3'd0;
            bit_cnt  <= CW'(1);
            done     <= ONE_BIT_LAST;
          end
        end
        ST_DATA: begin
          if (bit_cnt < PW_C) begin
            out     <= msb;
            bit_cnt <= bit_cnt + CW'(1);
            done    <= (bit_cnt == LAST_IDX) && !PAR_EN;
          end else if (PAR_EN) begin
            state   <= ST_PARITY;
            out     <= parity;
            bit_cnt <= '0;
            done    <= 1'b1;
          end else begin
            out     <= 1'b0;
            out_en  <= 1'b0;
            bit_cnt <= '0;
            if (GAP == 0) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= GAP_INIT;
            end
          end
        end
        ST_PARITY: begin
          out    <= 1'b0;
          out_en <= 1'b0;
          if (GAP == 0) begin
            state <= ST_IDLE;
          end else begin
            state   <= ST_GAP;
            gap_cnt <= GAP_INIT;
          end
        end
        ST_GAP: begin
          out    <= 1'b0;
          out_en <= 1'b0;
          if (gap_cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          sync_cnt <= 3'd0;
          bit_cnt  <= '0;
          gap_cnt  <= 4'd0;
          out      <= 1'b0;
          out_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule
